reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares one N-bit storage register among R requesters that each want to load a value into it.
- Round-robin arbitration; the grant is a one-cycle pulse; the winner's data is captured on the same edge that raises its grant.
- Sits in front of the team's simple clocked register and replaces its single always-load input path with an arbitrated write path plus status outputs.

Parameters:
- n, 4, width of the stored word.
- R, 4, number of requesters (2..16).
- IW, $clog2(R), requester index width (derived, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  R  per-requester write request; level, held until granted.
- I  input  R*n  packed write data; requester k drives I[k*n +: n].
- gnt  output  R  one-hot grant pulse; registered.
- Q  output  n  stored word; registered.
- q_valid  output  1  Q holds a written value since reset.
- owner  output  IW  index of the last requester written.
- busy  output  1  high while in GRANT state.

Behaviour:
- Reset (rst_n=0, async, immediate):
  - gnt=0, Q=0, q_valid=0, owner=0, busy=0.
  - Internal ptr=0, state=IDLE.
  - Reset asserted mid-GRANT kills gnt at once; no partial write survives.
- FSM with two states, IDLE and GRANT.
- IDLE:
  - If req==0, hold all state.
  - Otherwise pick the winner w: the first k with req[k]=1, searching ptr, ptr+1, ... R-1, 0, ... ptr-1 (wraps modulo R).
  - On the next rising edge:
    - gnt <= one-hot(w); Q <= I[w*n +: n]; owner <= w; q_valid <= 1.
    - ptr <= (w==R-1) ? 0 : w+1.
    - state <= GRANT.
- GRANT:
  - gnt and busy are high for exactly this one cycle.
  - No arbitration and no capture happen in this cycle; the next edge clears gnt and returns to IDLE.
  - Peak rate is therefore one write per 2 cycles. Write latency from req seen in IDLE to Q updated is 1 edge.
- Requester handshake:
  - Requester k deasserts req[k] in the cycle it sees gnt[k]=1.
  - If req[k] is still high on return to IDLE, it is a new request and arbitrates normally.
- Round-robin fairness: a continuously requesting requester waits at most R-1 other grants.
- Changes on I while not granted have no effect on Q.
- Q, owner and q_valid hold between writes.
- Requests arriving during GRANT wait for IDLE; none are lost because req is level.
- Simultaneous requests: exactly one grant; the others stay pending.
- ptr wrap: a winner at R-1 sets ptr to 0.

Decomposition:
- Shared package reg_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - function onehot(idx, R);
  - index-width helper.
- One natural combinational sub-module: rr_priority_pick (inputs req, ptr; outputs w and any_req). It is reusable by other arbiters in the codebase.

Test Plan:
- Reset then idle: rst_n low 3 cycles, req=0 for 10 cycles -> Q=0, q_valid=0, gnt=0, busy=0 throughout.
- Single write: req=4'b0100, I[2]=4'hA -> after 1 edge gnt=4'b0100, Q=4'hA, owner=2, q_valid=1; next edge gnt=0; Q holds 4'hA.
- Round-robin, all requesting: req=4'b1111 held, I[k]=k+1 -> grant order 0,1,2,3,0 on every second edge; Q sequence 1,2,3,4,1.
- Wrap and skip: ptr=3 after granting 2, then req=4'b0011 -> grant requester 0 (not 1); ptr becomes 1.
- Late request during GRANT: req[1] rises in GRANT cycle -> not granted until the following IDLE edge; no write in the GRANT cycle.
- Async reset mid-grant: drop rst_n while gnt=4'b0001 (between edges) -> gnt, Q and q_valid go to 0 immediately; after release, the first req=4'b0010 grants requester 1.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the arbitrated register write path.
package reg_arb_pkg;

    localparam int unsigned MAX_REQ = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned r);
        return (r > 1) ? int'($clog2(r)) : 1;
    endfunction

    // One-hot of idx over r requesters; indices outside the range give zero.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx, input int unsigned r);
        logic [MAX_REQ-1:0] v;
        v = '0;
        if (32'(idx) < r) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo R.
module rr_priority_pick
    import reg_arb_pkg::*;
#(
    parameter  int unsigned R  = 4,
    localparam int unsigned IW = idx_width(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] w,
    output logic          any_req
);

    int unsigned k;

    always_comb begin
        w       = '0;
        any_req = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < R; i++) begin
            k = 32'(ptr) + i;
            if (k >= R) begin
                k = k - R;
            end
            if (!any_req && req[IW'(k)]) begin
                any_req = 1'b1;
                w       = IW'(k);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shared N-bit register with a round-robin arbitrated write path and status outputs.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int unsigned n  = 4,
    parameter  int unsigned R  = 4,
    localparam int unsigned IW = idx_width(R)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req,
    input  logic [R*n-1:0]  I,
    output logic [R-1:0]    gnt,
    output logic [n-1:0]    Q,
    output logic            q_valid,
    output logic [IW-1:0]   owner,
    output logic            busy
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [R-1:0]  gnt_q, gnt_d;
    logic [n-1:0]  q_q, q_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          busy_q, busy_d;

    logic [IW-1:0] win_c;
    logic          any_req_c;
    logic [n-1:0]  din [R];

    for (genvar g = 0; g < R; g++) begin : g_din
        assign din[g] = I[g*n +: n];
    end

    rr_priority_pick #(.R(R)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .w       (win_c),
        .any_req (any_req_c)
    );

    // Arbitrate and capture in IDLE; GRANT is a single dead cycle that clears the pulse.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        q_d     = q_q;
        valid_d = valid_q;
        owner_d = owner_q;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    gnt_d   = R'(onehot(4'(win_c), R));
                    q_d     = din[win_c];
                    owner_d = win_c;
                    valid_d = 1'b1;
                    ptr_d   = (win_c == IW'(R - 1)) ? '0 : win_c + IW'(1);
                    busy_d  = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign Q       = q_q;
    assign q_valid = valid_q;
    assign owner   = owner_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_reg_write_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned R  = 4;
    localparam int unsigned IW = 2;

    logic            clk;
    logic            rst_n;
    logic [R-1:0]    req;
    logic [R*N-1:0]  din;
    logic [R-1:0]    gnt;
    logic [N-1:0]    q;
    logic            q_valid;
    logic [IW-1:0]   owner;
    logic            busy;

    int n_tests;
    int n_fail;

    // Reference model state
    bit           m_grant;
    int           m_ptr;
    logic [N-1:0] m_q;
    int           m_owner;
    bit           m_valid;
    logic [R-1:0] m_gnt;

    reg_write_arbiter #(.n(N), .R(R)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .I       (din),
        .gnt     (gnt),
        .Q       (q),
        .q_valid (q_valid),
        .owner   (owner),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_grant = 0;
        m_ptr   = 0;
        m_q     = '0;
        m_owner = 0;
        m_valid = 0;
        m_gnt   = '0;
    endtask

    // Predict the effect of the next rising edge from the current req/din.
    task automatic model_edge();
        int win;
        if (m_grant) begin
            m_grant = 0;
            m_gnt   = '0;
        end else if (req != '0) begin
            win = -1;
            for (int i = 0; i < int'(R); i++) begin
                int k;
                k = (m_ptr + i) % int'(R);
                if (win < 0 && req[k]) win = k;
            end
            m_gnt   = '0;
            m_gnt[win] = 1'b1;
            m_q     = din[win*N +: N];
            m_owner = win;
            m_valid = 1;
            m_ptr   = (win + 1) % int'(R);
            m_grant = 1;
        end else begin
            m_gnt = '0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] slot(input int k);
        logic [R*N-1:0] v;
        v = din;
        return v[k*N +: N];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if ({gnt, q, q_valid, owner, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got gnt=%b Q=%h v=%b own=%0d busy=%b, expected all zero",
                         c, gnt, q, q_valid, owner, busy);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            din = R*N'($urandom);
            tick();
            n_tests++;
            if (gnt !== '0 || q !== '0 || q_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_req cyc%0d: got gnt=%b Q=%h v=%b busy=%b, expected 0/0/0/0",
                         c, gnt, q, q_valid, busy);
            end
        end
    endtask

    task automatic test_single_write();
        din = R*N'($urandom);
        din[2*N +: N] = 4'hA;
        req = 4'b0100;
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || q !== 4'hA || owner !== 2'd2 || q_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write: got gnt=%b Q=%h own=%0d v=%b busy=%b, expected 0100/a/2/1/1",
                     gnt, q, owner, q_valid, busy);
        end
        req = '0;
        din = R*N'($urandom);
        tick();
        n_tests++;
        if (gnt !== '0 || q !== 4'hA || busy !== 1'b0 || q_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write_hold: got gnt=%b Q=%h busy=%b v=%b, expected 0000/a/0/1",
                     gnt, q, busy, q_valid);
        end
    endtask

    task automatic test_wrap_skip();
        din = R*N'($urandom);
        req = 4'b0011;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || owner !== 2'd0 || q !== slot(0)) begin
            n_fail++;
            $display("FAIL wrap_skip: got gnt=%b own=%0d Q=%h, expected 0001/0/%h", gnt, owner, q, slot(0));
        end
        req = 4'b0010;
        tick();
        n_tests++;
        if (gnt !== '0) begin
            n_fail++;
            $display("FAIL wrap_skip_gap: got gnt=%b, expected 0000", gnt);
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || q !== slot(1)) begin
            n_fail++;
            $display("FAIL wrap_skip_next: got gnt=%b own=%0d Q=%h, expected 0010/1/%h", gnt, owner, q, slot(1));
        end
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_q;
        rst_n = 1'b0;
        req   = '0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < int'(R); k++) din[k*N +: N] = N'(k + 1);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_q = N'(exp_idx[j] + 1);
            tick();
            n_tests++;
            if (gnt !== R'(1 << exp_idx[j]) || q !== exp_q || owner !== IW'(exp_idx[j])) begin
                n_fail++;
                $display("FAIL round_robin grant%0d: got gnt=%b Q=%h own=%0d, expected gnt=%b Q=%h own=%0d",
                         j, gnt, q, owner, R'(1 << exp_idx[j]), exp_q, exp_idx[j]);
            end
            tick();
            n_tests++;
            if (gnt !== '0 || q !== exp_q || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL round_robin gap%0d: got gnt=%b Q=%h busy=%b, expected 0000/%h/0",
                         j, gnt, q, busy, exp_q);
            end
        end
        req = '0;
    endtask

    task automatic test_late_request();
        logic [N-1:0] q0;
        din = R*N'($urandom);
        req = 4'b0001;
        tick();
        q0 = slot(0);
        n_tests++;
        if (gnt !== 4'b0001 || q !== q0) begin
            n_fail++;
            $display("FAIL late_req_first: got gnt=%b Q=%h, expected 0001/%h", gnt, q, q0);
        end
        req = 4'b0010;
        din = R*N'($urandom);
        tick();
        n_tests++;
        if (gnt !== '0 || q !== q0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL late_req_in_grant: got gnt=%b Q=%h own=%0d, expected 0000/%h/0", gnt, q, owner, q0);
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0010 || q !== slot(1) || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL late_req_granted: got gnt=%b Q=%h own=%0d, expected 0010/%h/1", gnt, q, owner, slot(1));
        end
        req = '0;
        tick();
    endtask

    task automatic test_async_reset();
        din = R*N'($urandom);
        din[0 +: N] = 4'h5;
        req = 4'b0001;
        tick();
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL async_pre: got gnt=%b, expected 0001", gnt);
        end
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        model_reset();
        n_tests++;
        if (gnt !== '0 || q !== '0 || q_valid !== 1'b0 || busy !== 1'b0 || owner !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b Q=%h v=%b busy=%b own=%0d, expected all zero",
                     gnt, q, q_valid, busy, owner);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b0010;
        tick();
        n_tests++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || q !== slot(1) || q_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_after: got gnt=%b own=%0d Q=%h v=%b, expected 0010/1/%h/1",
                     gnt, owner, q, q_valid, slot(1));
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        int waits [R];
        logic [R-1:0] req_at_edge;
        for (int k = 0; k < int'(R); k++) waits[k] = 0;
        req = '0;
        for (int c = 0; c < 400; c++) begin
            din = R*N'($urandom);
            req_at_edge = req;
            tick();
            n_tests++;
            if (gnt !== m_gnt || q !== m_q || q_valid !== m_valid || owner !== IW'(m_owner) || busy !== m_grant) begin
                n_fail++;
                $display("FAIL random cyc%0d: got gnt=%b Q=%h v=%b own=%0d busy=%b, expected gnt=%b Q=%h v=%b own=%0d busy=%b",
                         c, gnt, q, q_valid, owner, busy, m_gnt, m_q, m_valid, m_owner, m_grant);
            end
            if (m_gnt != '0) begin
                for (int k = 0; k < int'(R); k++) begin
                    if (m_gnt[k]) begin
                        n_tests++;
                        if (waits[k] > int'(R) - 1) begin
                            n_fail++;
                            $display("FAIL fairness req%0d: waited %0d grants, limit %0d", k, waits[k], R - 1);
                        end
                        waits[k] = 0;
                    end else if (req_at_edge[k]) begin
                        waits[k]++;
                    end
                end
            end
            for (int k = 0; k < int'(R); k++) begin
                if (gnt[k]) req[k] = 1'b0;
                else if (!req[k] && ($urandom % 3 == 0)) req[k] = 1'b1;
            end
        end
        req = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = '0;
        din     = '0;
        test_reset();
        test_single_write();
        test_wrap_skip();
        test_round_robin();
        test_late_request();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
